// File: rtl/pe_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_seq_pkg
// Description : Shared definitions for the PE-array sequencer. Holds the
//               default array geometry, the vector-count width and the FSM
//               state encoding. Imported by the interface, the skew decoder
//               and the sequencer top.
// Revision    : 1.0  initial release
// ============================================================================
package pe_seq_pkg;

    localparam int ROWS_DEF = 4;   // PE rows
    localparam int COLS_DEF = 4;   // PE columns (drain depth)
    localparam int LW_DEF   = 8;   // vector-count field width

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOADW  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage : pe_seq_pkg
`default_nettype wire

// File: rtl/pe_array_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_seq_if
// Description : Control/strobe bundle between the PE-array sequencer and its
//               environment.
//               master : sequencer side (drives strobes, status, counter)
//               slave  : environment side (drives start, cfg_len, stall)
//   start        request a run (sampled only when idle)
//   cfg_len      number of activation vectors L
//   stall        freeze the sequence
//   w_load_en    weight-load strobe,  w_row  row receiving the weight
//   a_rd_en      activation read,     a_rd_addr  read address
//   fire_row     per-row PE fire enables
//   busy / done  status and one-cycle completion pulse
//   perf_cycles  busy-cycle counter (zero unless SEQ_PERF_CNT_EN)
// Revision    : 1.0  initial release
// ============================================================================
interface pe_array_seq_if
    import pe_seq_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int LW   = LW_DEF
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            start;
    logic [LW-1:0]   cfg_len;
    logic            stall;
    logic            w_load_en;
    logic [RW-1:0]   w_row;
    logic            a_rd_en;
    logic [LW-1:0]   a_rd_addr;
    logic [ROWS-1:0] fire_row;
    logic            busy;
    logic            done;
    logic [15:0]     perf_cycles;

    modport master (
        input  start, cfg_len, stall,
        output w_load_en, w_row, a_rd_en, a_rd_addr, fire_row, busy, done,
               perf_cycles
    );

    modport slave (
        output start, cfg_len, stall,
        input  w_load_en, w_row, a_rd_en, a_rd_addr, fire_row, busy, done,
               perf_cycles
    );

endinterface : pe_array_seq_if
`default_nettype wire

// File: rtl/pe_fire_skew.sv
`default_nettype none
// ============================================================================
// Module      : pe_fire_skew
// Description : Diagonal-skew fire decoder. Row r fires while
//               r <= t < r + len_q, so each row sees the activation
//               wavefront one cycle after the row above it.
//   i_t      stream counter (LW+1 bits so len_q+r cannot wrap)
//   i_len_q  latched vector count, zero-extended to the same width
//   i_enable gates the whole mask (STREAM and not stalled)
//   o_mask   ROWS-bit fire mask
// Revision    : 1.0  initial release
// ============================================================================
module pe_fire_skew #(
    parameter int ROWS = 4,
    parameter int TW   = 9
) (
    input  logic [TW-1:0]   i_t,
    input  logic [TW-1:0]   i_len_q,
    input  logic            i_enable,
    output logic [ROWS-1:0] o_mask
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign o_mask[r] = i_enable
                         && (i_t >= TW'(r))
                         && (i_t <  (i_len_q + TW'(r)));
    end

endmodule : pe_fire_skew
`default_nettype wire

// File: rtl/pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_seq
// Description : Run sequencer for a ROWS x COLS PE array. A run loads one
//               weight per row (LOADW), streams L activation vectors with a
//               diagonal fire skew (STREAM), waits COLS cycles for the
//               partial sums to leave the array (DRAIN) and pulses done.
//               All outputs are Moore-decoded from state/t/len_q; stall only
//               masks the strobes and freezes progress.
//   clk, rst   clock, asynchronous active-high reset
//   bus        pe_array_seq_if.master (start/cfg_len/stall in, strobes out)
// Build option: define SEQ_PERF_CNT_EN to include the busy-cycle counter;
//               otherwise perf_cycles is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module pe_array_seq
    import pe_seq_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pe_array_seq_if.master bus
);

    // One extra bit so len_q + ROWS - 2 and len_q + r never wrap.
    localparam int TW = LW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [2:0]      r_state;
    logic [TW-1:0]   r_t;
    logic [LW-1:0]   r_len_q;

    logic [TW-1:0]   w_len_ext;
    logic            w_start_acc;
    logic            w_loadw_last;
    logic            w_stream_last;
    logic            w_drain_last;
    logic            w_in_loadw;
    logic            w_in_stream;
    logic            w_rd;
    logic [ROWS-1:0] w_fire;

    assign w_len_ext     = {1'b0, r_len_q};
    assign w_start_acc   = (r_state == ST_IDLE) && bus.start && !bus.stall;
    assign w_loadw_last  = (r_t == TW'(ROWS - 1));
    // STREAM is only entered with len_q >= 1, so this never underflows.
    assign w_stream_last = (r_t == (w_len_ext + TW'(ROWS) - TW'(2)));
    assign w_drain_last  = (r_t == TW'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_len_q <= '0;
        end else if (r_state == ST_DONE) begin
            // DONE always retires after one cycle, stall or not.
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else if (!bus.stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        r_len_q <= bus.cfg_len;
                        r_t     <= '0;
                        r_state <= ST_LOADW;
                    end
                end
                ST_LOADW: begin
                    if (w_loadw_last) begin
                        r_t     <= '0;
                        r_state <= (r_len_q == '0) ? ST_DONE : ST_STREAM;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_stream_last) begin
                        r_t     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_last) begin
                        r_t     <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_t     <= '0;
                end
            endcase
        end
    end

    // ---------------- Moore output decode ----------------
    assign w_in_loadw  = (r_state == ST_LOADW);
    assign w_in_stream = (r_state == ST_STREAM);
    assign w_rd        = w_in_stream && (r_t < w_len_ext) && !bus.stall;

    pe_fire_skew #(
        .ROWS (ROWS),
        .TW   (TW)
    ) u_fire_skew (
        .i_t      (r_t),
        .i_len_q  (w_len_ext),
        .i_enable (w_in_stream && !bus.stall),
        .o_mask   (w_fire)
    );

    assign bus.w_load_en = w_in_loadw && !bus.stall;
    assign bus.w_row     = w_in_loadw ? r_t[RW-1:0] : '0;
    assign bus.a_rd_en   = w_rd;
    assign bus.a_rd_addr = w_rd ? r_t[LW-1:0] : '0;
    assign bus.fire_row  = w_fire;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);

`ifdef SEQ_PERF_CNT_EN
    // Counts every non-IDLE cycle (stalls included) and sticks at all-ones.
    logic [15:0] r_perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_start_acc) begin
            r_perf <= '0;
        end else if ((r_state != ST_IDLE) && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign bus.perf_cycles = r_perf;
`else
    assign bus.perf_cycles = 16'h0000;
`endif

endmodule : pe_array_seq
`default_nettype wire

// File: tb/tb_pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_seq
// Description : Directed self-checking bench for pe_array_seq (ROWS=COLS=4,
//               LW=8). Cycle c is the clock period following rising edge
//               c-1; the start that launches a run is sampled on edge 0.
//               Observed strobes are packed per cycle as
//               {w_load_en, w_row, a_rd_en, a_rd_addr, fire_row, busy, done}.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pe_array_seq;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LW   = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_array_seq_if #(.ROWS(ROWS), .LW(LW)) bus ();

    pe_array_seq #(
        .ROWS (ROWS),
        .COLS (COLS),
        .LW   (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [17:0] cap_obs  [0:39];
    logic [15:0] cap_perf [0:39];

    function automatic logic [17:0] obs_now();
        return {bus.w_load_en, bus.w_row, bus.a_rd_en, bus.a_rd_addr,
                bus.fire_row, bus.busy, bus.done};
    endfunction

    // Launch a run with start on the next edge and capture ncyc cycles.
    // stall is high for cycles st_at .. st_at+st_n-1.
    task automatic run_seq(input int len, input int ncyc, input int st_at,
                           input int st_n, input bit hold);
        bus.cfg_len = LW'(len);
        bus.start   = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (!hold) bus.start = 1'b0;
            bus.stall = (c >= st_at) && (c < st_at + st_n);
            #1;
            cap_obs[c]  = obs_now();
            cap_perf[c] = bus.perf_cycles;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stall   = 1'b0;
        bus.cfg_len = '0;
        repeat (2) @(posedge clk);
        #1;
        obs = obs_now();
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0);
        end
        vectors++;
        if (bus.perf_cycles !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_perf: got %0d expected 0", bus.perf_cycles);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_nominal();
        logic [17:0] exp;
        logic [3:0]  ef;
        int          t;
        run_seq(8, 22, 0, 0, 1'b0);
        for (int c = 1; c <= 22; c++) begin
            t = c - 5;
            for (int r = 0; r < 4; r++)
                ef[r] = (c >= 5) && (c <= 15) && (r <= t) && (t < r + 8);
            exp = {(c <= 4), (c <= 4) ? 2'(c - 1) : 2'd0,
                   (c >= 5 && c <= 12), (c >= 5 && c <= 12) ? 8'(t) : 8'd0,
                   ef, (c <= 20), (c == 20)};
            vectors++;
            if (cap_obs[c] !== exp) begin
                miscompares++;
                $display("FAIL nominal_c%0d: got %h expected %h", c, cap_obs[c], exp);
            end
        end
        vectors++;
        if (cap_obs[5][5:2] !== 4'b0001) begin
            miscompares++;
            $display("FAIL fire_c5: got %b expected 0001", cap_obs[5][5:2]);
        end
        vectors++;
        if (cap_obs[8][5:2] !== 4'b1111) begin
            miscompares++;
            $display("FAIL fire_c8: got %b expected 1111", cap_obs[8][5:2]);
        end
        vectors++;
        if (cap_obs[15][5:2] !== 4'b1000) begin
            miscompares++;
            $display("FAIL fire_c15: got %b expected 1000", cap_obs[15][5:2]);
        end
`ifdef SEQ_PERF_CNT_EN
        vectors++;
        if (cap_perf[20] !== 16'd19) begin
            miscompares++;
            $display("FAIL perf_nominal: got %0d expected 19", cap_perf[20]);
        end
`else
        vectors++;
        if (cap_perf[20] !== 16'd0) begin
            miscompares++;
            $display("FAIL perf_tied: got %0d expected 0", cap_perf[20]);
        end
`endif
    endtask

    task automatic test_len_zero();
        logic [17:0] exp;
        run_seq(0, 8, 0, 0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            exp = {(c <= 4), (c <= 4) ? 2'(c - 1) : 2'd0, 1'b0, 8'd0, 4'd0,
                   (c <= 5), (c == 5)};
            vectors++;
            if (cap_obs[c] !== exp) begin
                miscompares++;
                $display("FAIL len0_c%0d: got %h expected %h", c, cap_obs[c], exp);
            end
        end
    endtask

    task automatic test_stall_stream();
        logic [17:0] exp;
        logic [3:0]  ef;
        int          t;
        bit          stl;
        bit          strm;
        run_seq(8, 25, 7, 3, 1'b0);
        for (int c = 1; c <= 25; c++) begin
            stl  = (c >= 7) && (c <= 9);
            strm = (c >= 5) && (c <= 18);
            t    = (c <= 7) ? c - 5 : ((c <= 9) ? 2 : c - 8);
            for (int r = 0; r < 4; r++)
                ef[r] = strm && !stl && (r <= t) && (t < r + 8);
            exp = {(c <= 4), (c <= 4) ? 2'(c - 1) : 2'd0,
                   strm && !stl && (t < 8),
                   (strm && !stl && (t < 8)) ? 8'(t) : 8'd0,
                   ef, (c <= 23), (c == 23)};
            vectors++;
            if (cap_obs[c] !== exp) begin
                miscompares++;
                $display("FAIL stall_c%0d: got %h expected %h", c, cap_obs[c], exp);
            end
        end
        vectors++;
        if (cap_obs[10][5:2] !== 4'b0111) begin
            miscompares++;
            $display("FAIL stall_resume_fire: got %b expected 0111", cap_obs[10][5:2]);
        end
`ifdef SEQ_PERF_CNT_EN
        vectors++;
        if (cap_perf[23] !== 16'd22) begin
            miscompares++;
            $display("FAIL perf_stall: got %0d expected 22", cap_perf[23]);
        end
`endif
    endtask

    task automatic test_stall_loadw_done();
        // stall in LOADW cycle 2 pushes done from cycle 5 to 6
        run_seq(0, 8, 2, 1, 1'b0);
        vectors++;
        if (cap_obs[2][17] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_loadw_wl: got %b expected 0", cap_obs[2][17]);
        end
        vectors++;
        if (cap_obs[3][17:15] !== 3'b101) begin
            miscompares++;
            $display("FAIL stall_loadw_row: got %b expected 101", cap_obs[3][17:15]);
        end
        vectors++;
        if ({cap_obs[5][0], cap_obs[6][0], cap_obs[7][1]} !== 3'b010) begin
            miscompares++;
            $display("FAIL stall_loadw_done: got %b expected 010",
                     {cap_obs[5][0], cap_obs[6][0], cap_obs[7][1]});
        end
        // stall rising in DONE must not extend done
        run_seq(0, 7, 5, 2, 1'b0);
        vectors++;
        if (cap_obs[5][1:0] !== 2'b11) begin
            miscompares++;
            $display("FAIL stall_done_pulse: got %b expected 11", cap_obs[5][1:0]);
        end
        vectors++;
        if (cap_obs[6][1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_done_exit: got %b expected 00", cap_obs[6][1:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [17:0] obs;
        int          ndone;
        run_seq(8, 9, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        obs = obs_now();
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h expected %h", obs, 18'h0);
        end
        #1;
        rst = 1'b0;
        run_seq(1, 15, 0, 0, 1'b0);
        ndone = 0;
        for (int c = 1; c <= 15; c++) ndone += int'(cap_obs[c][0]);
        vectors++;
        if (cap_obs[13][1:0] !== 2'b11 || ndone != 1) begin
            miscompares++;
            $display("FAIL len1_done: got %b count %0d expected 11 count 1",
                     cap_obs[13][1:0], ndone);
        end
        vectors++;
        if ({cap_obs[5][14], cap_obs[5][5:2], cap_obs[6][14]} !== 6'b100010) begin
            miscompares++;
            $display("FAIL len1_c5: got %b expected 100010",
                     {cap_obs[5][14], cap_obs[5][5:2], cap_obs[6][14]});
        end
        vectors++;
        if (cap_obs[8][5:2] !== 4'b1000) begin
            miscompares++;
            $display("FAIL len1_c8_fire: got %b expected 1000", cap_obs[8][5:2]);
        end
        vectors++;
        if (cap_obs[14][1] !== 1'b0) begin
            miscompares++;
            $display("FAIL len1_idle: got %b expected 0", cap_obs[14][1]);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        run_seq(8, 22, 0, 0, 1'b1);
        ndone = 0;
        for (int c = 1; c <= 21; c++) ndone += int'(cap_obs[c][0]);
        vectors++;
        if (ndone != 1 || cap_obs[20][0] !== 1'b1) begin
            miscompares++;
            $display("FAIL held_one_run: got count %0d done20 %b expected 1 1",
                     ndone, cap_obs[20][0]);
        end
        vectors++;
        if (cap_obs[21][1] !== 1'b0) begin
            miscompares++;
            $display("FAIL held_idle_gap: got %b expected 0", cap_obs[21][1]);
        end
        vectors++;
        if (cap_obs[22][17:15] !== 3'b100) begin
            miscompares++;
            $display("FAIL held_restart: got %b expected 100", cap_obs[22][17:15]);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_len_zero();
        test_stall_stream();
        test_stall_loadw_done();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pe_array_seq
`default_nettype wire

// File: doc/pe_array_seq.md
PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of PE rows in the array.
REQ-002 SHALL have parameter COLS, default 4, number of PE columns (drain depth).
REQ-003 SHALL have parameter LW, default 8, width of the vector-count field.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request a run; sampled only in IDLE.
REQ-007 SHALL have port cfg_len  in  LW  number of activation vectors L; latched on accepted start.
REQ-008 SHALL have port stall  in  1  freezes the sequence while high.
REQ-009 SHALL have port w_load_en  out  1  weight-load strobe to the array.
REQ-010 SHALL have port w_row  out  $clog2(ROWS)  row receiving the weight this cycle.
REQ-011 SHALL have port a_rd_en  out  1  activation-buffer read enable.
REQ-012 SHALL have port a_rd_addr  out  LW  activation-buffer read address.
REQ-013 SHALL have port fire_row  out  ROWS  per-row PE fire enables.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port perf_cycles  out  16  busy-cycle counter; see Configuration.

Function
REQ-017 SHALL implement states IDLE, LOADW, STREAM, DRAIN, DONE, held in one state register plus one counter t.
REQ-018 IDLE: start=1 SHALL latch cfg_len into len_q, clear t, and go to LOADW next cycle; start in any other state SHALL be ignored.
REQ-019 LOADW: SHALL drive w_load_en=1 and w_row=t for t=0..ROWS-1, then go to STREAM (t cleared); if len_q=0 it SHALL go to DONE instead.
REQ-020 STREAM: t SHALL run 0..len_q+ROWS-2, then go to DRAIN with t cleared.
REQ-021 STREAM: a_rd_en SHALL be 1 and a_rd_addr SHALL equal t while t<len_q, else a_rd_en=0.
REQ-022 STREAM: fire_row[r] SHALL be 1 iff r <= t < r+len_q (diagonal skew); it SHALL be 0 in all other states.
REQ-023 DRAIN: SHALL last exactly COLS cycles with all strobes low, then go to DONE.
REQ-024 DONE: done SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-025 Outputs SHALL be Moore-decoded from state, t and len_q only; no combinational path from start or cfg_len to any output.
REQ-026 Run length with L>=1 and no stall SHALL be ROWS+(L+ROWS-1)+COLS busy cycles before DONE.
REQ-027 stall=1 SHALL hold state, t and len_q, and SHALL force w_load_en, a_rd_en and fire_row to 0 that cycle; done SHALL NOT be delayed if stall rises while in DONE.
REQ-028 Comparisons on t SHALL use LW+1 bits so that len_q=2^LW-1 does not wrap.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, t=0, len_q=0, perf counter 0, and all outputs to 0, including mid-run.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-031 With SEQ_PERF_CNT_EN defined, perf_cycles SHALL clear on accepted start, increment each busy cycle (including stall cycles), and saturate at 16'hFFFF.
REQ-032 Without SEQ_PERF_CNT_EN, perf_cycles SHALL be tied to 0 and no counter SHALL be instantiated.

Structure
REQ-033 State enum and ROWS/COLS/LW defaults SHALL live in the shared package pe_seq_pkg.
REQ-034 fire_row skew decode SHALL be the sub-module pe_fire_skew (inputs t, len_q, enable; output ROWS-bit mask).

Verification
REQ-035 ROWS=COLS=4, start on edge 0 with cfg_len=8 -> w_load_en cycles 1-4 (w_row 0..3), STREAM cycles 5-15, DRAIN 16-19, done=1 only at cycle 20.
REQ-036 Same run, cycle 5 -> fire_row=4'b0001; cycle 8 -> 4'b1111; cycle 15 -> 4'b1000; a_rd_addr 0..7 on cycles 5-12.
REQ-037 cfg_len=0 -> LOADW 4 cycles, then done at cycle 5; fire_row and a_rd_en never 1.
REQ-038 stall held for 3 cycles at cycle 7 -> all strobes 0 for those 3 cycles; done moves to cycle 23.
REQ-039 rst pulsed at cycle 10 mid-STREAM -> busy, fire_row, a_rd_en 0 in that cycle; a new start with cfg_len=1 completes with done at cycle 4+4+4+1 after its start.
REQ-040 start=1 held high throughout the run -> exactly one run per return to IDLE; with SEQ_PERF_CNT_EN, perf_cycles=19 after the cfg_len=8 run.
